// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write integer register file with post-reset clear engine
module reg_file_2r1w #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    output logic            init_busy
);

    localparam logic       ST_INIT  = 1'b0;
    localparam logic       ST_READY = 1'b1;
    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    logic            state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            init_busy_q, init_busy_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    // Entry 0 is never written; reads of x0 are forced to zero below.
    logic [XLEN-1:0] mem_q [NREGS];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        init_busy_d = init_busy_q;
        mem_we      = 1'b0;
        mem_waddr   = A3;
        mem_wdata   = WD3;
        if (reset) begin
            state_d     = ST_INIT;
            ptr_d       = PTR_FIRST;
            init_busy_d = 1'b1;
        end else if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
            if (ptr_q == PTR_LAST) begin
                state_d     = ST_READY;
                init_busy_d = 1'b0;
            end else begin
                ptr_d = ptr_q + PTR_FIRST;
            end
        end else if (WE3 && (A3 != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        ptr_q       <= ptr_d;
        init_busy_q <= init_busy_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] data;
        if ((addr == '0) || (state_q != ST_READY)) begin
            data = '0;
        end else if ((BYPASS != 0) && WE3 && (A3 == addr)) begin
            data = WD3;
        end else begin
            data = mem_q[addr];
        end
        return data;
    endfunction

    always_comb begin
        RD1 = read_port(A1);
        RD2 = read_port(A2);
    end

    assign init_busy = init_busy_q;

endmodule
